// File: rtl/sd_emmc_card_pkg.sv
// rtl/sd_emmc_card_pkg.sv - shared encodings for the eMMC card command responder
package sd_emmc_card_pkg;

  // Card states as reported on card_state_o
  localparam logic [3:0] CARD_IDLE  = 4'd0;
  localparam logic [3:0] CARD_READY = 4'd1;
  localparam logic [3:0] CARD_IDENT = 4'd2;
  localparam logic [3:0] CARD_STBY  = 4'd3;
  localparam logic [3:0] CARD_TRAN  = 4'd4;

  // Command indices the card understands
  localparam logic [5:0] CMD0 = 6'd0;
  localparam logic [5:0] CMD1 = 6'd1;
  localparam logic [5:0] CMD2 = 6'd2;
  localparam logic [5:0] CMD3 = 6'd3;
  localparam logic [5:0] CMD7 = 6'd7;
  localparam logic [5:0] CMD8 = 6'd8;

  // Card status bit positions
  localparam int ST_COM_CRC_ERROR   = 23;
  localparam int ST_ILLEGAL_COMMAND = 22;
  localparam int ST_STATE_LSB       = 9;
  localparam int ST_READY_FOR_DATA  = 8;

  // Frame lengths on the CMD line
  localparam logic [7:0] SHORT_FRAME_LEN = 8'd48;
  localparam logic [7:0] LONG_FRAME_LEN  = 8'd136;

  typedef enum logic [1:0] {
    RESP_NONE,
    RESP_R1,
    RESP_R2,
    RESP_R3
  } resp_kind_t;

  // R1 card status word: error flags, current state and READY_FOR_DATA
  function automatic logic [31:0] r1_status(input logic crc_err, input logic illegal,
                                            input logic [3:0] state);
    logic [31:0] s;
    s = 32'h0;
    s[ST_COM_CRC_ERROR]              = crc_err;
    s[ST_ILLEGAL_COMMAND]            = illegal;
    s[ST_STATE_LSB +: 4]             = state;
    s[ST_READY_FOR_DATA]             = 1'b1;
    return s;
  endfunction

endpackage

// File: rtl/sd_emmc_card_cmd_responder_crc7.sv
// rtl/sd_emmc_card_cmd_responder_crc7.sv - serial CRC7 (x^7 + x^3 + 1)
module sd_emmc_crc7 (
  input  logic       sd_clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       din,
  output logic [6:0] crc
);

  // Shift one bit per enabled cycle; clear has priority. Feeding crc[6]
  // back in leaves a zero feedback term, which turns the register into a
  // plain left shifter used to serialise the remainder.
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      crc <= 7'h00;
    end else if (clr) begin
      crc <= 7'h00;
    end else if (en) begin
      crc <= {crc[5:0], 1'b0} ^ ({7{din ^ crc[6]}} & 7'h09);
    end
  end

endmodule

// File: rtl/sd_emmc_card_cmd_responder.sv
// rtl/sd_emmc_card_cmd_responder.sv - device-side eMMC command receiver and responder
module sd_emmc_card_cmd_responder
  import sd_emmc_card_pkg::*;
#(
  parameter logic [31:0] OCR_VALUE   = 32'h40FF8080,
  parameter int          NCR         = 2,
  parameter logic [15:0] DEFAULT_RCA = 16'h0001
) (
  input  logic         sd_clk,
  input  logic         rst,
  input  logic         cmd_i,
  output logic         cmd_o,
  output logic         cmd_oe,
  input  logic [119:0] cid_i,
  output logic [3:0]   card_state_o,
  output logic [15:0]  rca_o,
  output logic         cmd_valid_o,
  output logic [5:0]   cmd_index_o,
  output logic [31:0]  cmd_arg_o,
  output logic         crc_err_o
);

  localparam logic [2:0] RX_WAIT  = 3'd0;
  localparam logic [2:0] RX_SHIFT = 3'd1;
  localparam logic [2:0] RX_CHECK = 3'd2;
  localparam logic [2:0] TX_GAP   = 3'd3;
  localparam logic [2:0] TX_SHIFT = 3'd4;

  localparam logic [3:0] NCR_CYC = 4'(NCR);

  logic [2:0]   fsm;
  logic [5:0]   rx_cnt;
  logic [47:0]  rx_sreg;
  logic [6:0]   rx_crc;
  logic         st_crc_err;
  logic         st_illegal;

  logic [135:0] tx_sreg;
  logic [7:0]   tx_cnt;
  logic [7:0]   tx_len;
  logic [7:0]   tx_feed_lo;
  logic [7:0]   tx_crc_pos;
  logic         tx_use_crc;
  logic         tx_is_r1;
  logic [3:0]   gap_cnt;
  logic [6:0]   tx_crc;

  logic         chk;
  logic         rx_ok;
  logic [5:0]   rx_idx;
  logic [31:0]  rx_arg;
  logic         rx_crc_en;

  logic [3:0]   dec_state;
  resp_kind_t   dec_resp;
  logic         dec_illegal;
  logic         dec_rca_load;
  logic         dec_rca_reset;

  logic [7:0]   tx_idx;
  logic         tx_in_crc;
  logic         tx_in_feed;
  logic         tx_bit;
  logic         gap_done;
  logic         tx_step;
  logic         tx_crc_en;
  logic         tx_crc_clr;

  assign chk       = (fsm == RX_CHECK);
  assign rx_idx    = rx_sreg[45:40];
  assign rx_arg    = rx_sreg[39:8];
  assign rx_ok     = ~rx_sreg[47] & rx_sreg[46] & rx_sreg[0] & (rx_sreg[7:1] == rx_crc);
  // Start bit is always zero and leaves a cleared CRC at zero, so only
  // bits 46..8 (counts 1..39) need to be fed.
  assign rx_crc_en = (fsm == RX_SHIFT) && (rx_cnt <= 6'd39);

  sd_emmc_crc7 u_rx_crc (
    .sd_clk (sd_clk),
    .rst    (rst),
    .clr    (fsm == RX_WAIT),
    .en     (rx_crc_en),
    .din    (cmd_i),
    .crc    (rx_crc)
  );

  // Command table: next card state, response kind and side effects
  always_comb begin
    dec_state     = card_state_o;
    dec_resp      = RESP_NONE;
    dec_illegal   = 1'b0;
    dec_rca_load  = 1'b0;
    dec_rca_reset = 1'b0;
    case (rx_idx)
      CMD0: begin
        dec_state     = CARD_IDLE;
        dec_rca_reset = 1'b1;
      end
      CMD1: begin
        if (card_state_o == CARD_IDLE) begin
          dec_state = CARD_READY;
          dec_resp  = RESP_R3;
        end else dec_illegal = 1'b1;
      end
      CMD2: begin
        if (card_state_o == CARD_READY) begin
          dec_state = CARD_IDENT;
          dec_resp  = RESP_R2;
        end else dec_illegal = 1'b1;
      end
      CMD3: begin
        if (card_state_o == CARD_IDENT) begin
          dec_state    = CARD_STBY;
          dec_resp     = RESP_R1;
          dec_rca_load = 1'b1;
        end else dec_illegal = 1'b1;
      end
      CMD7: begin
        if (card_state_o == CARD_STBY && rx_arg[31:16] == rca_o) begin
          dec_state = CARD_TRAN;
          dec_resp  = RESP_R1;
        end else if (card_state_o == CARD_TRAN && rx_arg[31:16] != rca_o) begin
          dec_state = CARD_STBY;
        end else dec_illegal = 1'b1;
      end
      CMD8: begin
        if (card_state_o == CARD_TRAN) dec_resp = RESP_R1;
        else dec_illegal = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Transmit bit selection: CRC field comes from the TX CRC register,
  // everything else from the preloaded frame shifter.
  assign tx_idx     = (fsm == TX_SHIFT) ? tx_cnt : 8'd0;
  assign tx_in_crc  = tx_use_crc && (tx_idx >= tx_crc_pos) && (tx_idx < tx_crc_pos + 8'd7);
  assign tx_in_feed = tx_use_crc && (tx_idx >= tx_feed_lo) && (tx_idx < tx_crc_pos);
  assign tx_bit     = tx_in_crc ? tx_crc[6] : tx_sreg[135];
  assign gap_done   = (fsm == TX_GAP) && (gap_cnt == NCR_CYC);
  assign tx_step    = gap_done || ((fsm == TX_SHIFT) && (tx_cnt != tx_len));
  assign tx_crc_en  = tx_step && (tx_in_feed || tx_in_crc);
  assign tx_crc_clr = (fsm != TX_SHIFT) && !tx_crc_en;

  sd_emmc_crc7 u_tx_crc (
    .sd_clk (sd_clk),
    .rst    (rst),
    .clr    (tx_crc_clr),
    .en     (tx_crc_en),
    .din    (tx_bit),
    .crc    (tx_crc)
  );

  // Line-level FSM: receive a token, check it, optionally answer
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      fsm     <= RX_WAIT;
      rx_cnt  <= 6'd0;
      rx_sreg <= 48'h0;
    end else begin
      case (fsm)
        RX_WAIT: begin
          if (!cmd_i) begin
            fsm     <= RX_SHIFT;
            rx_cnt  <= 6'd1;
            rx_sreg <= 48'h0;
          end
        end
        RX_SHIFT: begin
          rx_sreg <= {rx_sreg[46:0], cmd_i};
          rx_cnt  <= rx_cnt + 6'd1;
          if (rx_cnt == 6'd47) fsm <= RX_CHECK;
        end
        RX_CHECK: fsm <= (rx_ok && dec_resp != RESP_NONE) ? TX_GAP : RX_WAIT;
        TX_GAP:   if (gap_done) fsm <= TX_SHIFT;
        TX_SHIFT: if (tx_cnt == tx_len) fsm <= RX_WAIT;
        default:  fsm <= RX_WAIT;
      endcase
    end
  end

  // Card-level state: card state, RCA, status error flags, decoded command
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      card_state_o <= CARD_IDLE;
      rca_o        <= DEFAULT_RCA;
      st_crc_err   <= 1'b0;
      st_illegal   <= 1'b0;
      cmd_valid_o  <= 1'b0;
      crc_err_o    <= 1'b0;
      cmd_index_o  <= 6'd0;
      cmd_arg_o    <= 32'h0;
    end else begin
      cmd_valid_o <= 1'b0;
      crc_err_o   <= 1'b0;
      if (chk) begin
        if (!rx_ok) begin
          crc_err_o  <= 1'b1;
          st_crc_err <= 1'b1;
        end else begin
          cmd_valid_o  <= 1'b1;
          cmd_index_o  <= rx_idx;
          cmd_arg_o    <= rx_arg;
          card_state_o <= dec_state;
          if (dec_rca_reset) rca_o <= DEFAULT_RCA;
          if (dec_rca_load) rca_o <= rx_arg[31:16];
          if (dec_illegal) st_illegal <= 1'b1;
        end
      end
      // The R1 now starting carries the flags, so they are reported once
      if (gap_done && tx_is_r1) begin
        st_crc_err <= 1'b0;
        st_illegal <= 1'b0;
      end
    end
  end

  // Response serialiser: frame preload, NCR gap, one bit per cycle
  always_ff @(posedge sd_clk or posedge rst) begin
    if (rst) begin
      cmd_o      <= 1'b1;
      cmd_oe     <= 1'b0;
      tx_sreg    <= 136'h0;
      tx_cnt     <= 8'd0;
      tx_len     <= SHORT_FRAME_LEN;
      tx_feed_lo <= 8'd0;
      tx_crc_pos <= 8'd40;
      tx_use_crc <= 1'b0;
      tx_is_r1   <= 1'b0;
      gap_cnt    <= 4'd0;
    end else begin
      case (fsm)
        RX_CHECK: begin
          gap_cnt <= 4'd1;
          case (dec_resp)
            RESP_R1: begin
              tx_sreg    <= {2'b00, rx_idx, r1_status(st_crc_err, st_illegal, card_state_o),
                             8'h01, 88'h0};
              tx_len     <= SHORT_FRAME_LEN;
              tx_feed_lo <= 8'd0;
              tx_crc_pos <= 8'd40;
              tx_use_crc <= 1'b1;
              tx_is_r1   <= 1'b1;
            end
            RESP_R2: begin
              tx_sreg    <= {8'h3F, cid_i, 8'h01};
              tx_len     <= LONG_FRAME_LEN;
              tx_feed_lo <= 8'd8;
              tx_crc_pos <= 8'd128;
              tx_use_crc <= 1'b1;
              tx_is_r1   <= 1'b0;
            end
            default: begin
              tx_sreg    <= {8'h3F, OCR_VALUE, 8'hFF, 88'h0};
              tx_len     <= SHORT_FRAME_LEN;
              tx_feed_lo <= 8'd0;
              tx_crc_pos <= 8'd40;
              tx_use_crc <= 1'b0;
              tx_is_r1   <= 1'b0;
            end
          endcase
        end
        TX_GAP: begin
          gap_cnt <= gap_cnt + 4'd1;
          if (gap_done) begin
            cmd_oe  <= 1'b1;
            cmd_o   <= tx_bit;
            tx_sreg <= {tx_sreg[134:0], 1'b0};
            tx_cnt  <= 8'd1;
          end
        end
        TX_SHIFT: begin
          if (tx_cnt == tx_len) begin
            cmd_oe <= 1'b0;
            cmd_o  <= 1'b1;
          end else begin
            cmd_o   <= tx_bit;
            tx_sreg <= {tx_sreg[134:0], 1'b0};
            tx_cnt  <= tx_cnt + 8'd1;
          end
        end
        default: begin
          cmd_oe <= 1'b0;
          cmd_o  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/sd_emmc_card_cmd_responder.md
Name: sd_emmc_card_cmd_responder

Overview:
Device-side eMMC command-line responder: deserialises 48-bit command tokens from the CMD line, checks CRC7, tracks the card identification/transfer state, and serialises R1/R2/R3 responses back. It is the far end of the host command path and acts as a synthesizable card model. The RAID0 bench and the FPGA loopback build instantiate one per emulated eMMC. It also exposes decoded commands to a future data-path responder.

Parameters:
OCR_VALUE, 32'h40FF8080, OCR returned in the R3 response to CMD1.
NCR, 2, sd_clk cycles between the command end bit and the response start bit (1..15).
DEFAULT_RCA, 16'h0001, RCA value at reset and after CMD0.

Ports:
sd_clk  in  1  card clock; every flop uses its rising edge.
rst  in  1  asynchronous reset, active-high.
cmd_i  in  1  CMD line as sampled from the host.
cmd_o  out  1  CMD line driven during a response.
cmd_oe  out  1  output enable for cmd_o.
cid_i  in  120  CID payload sent in R2.
card_state_o  out  4  current state: 0 IDLE, 1 READY, 2 IDENT, 3 STBY, 4 TRAN.
rca_o  out  16  current RCA.
cmd_valid_o  out  1  one-cycle pulse when a command with good CRC is accepted.
cmd_index_o  out  6  index of the last accepted command.
cmd_arg_o  out  32  argument of the last accepted command.
crc_err_o  out  1  one-cycle pulse when a received token fails CRC7 or the end-bit check.

Behaviour:
- Reset values: cmd_o=1, cmd_oe=0, card_state_o=IDLE, rca_o=DEFAULT_RCA, cmd_valid_o=0, cmd_index_o=0, cmd_arg_o=0, crc_err_o=0. Status error bits clear. The receiver is in RX_WAIT.
- Receiver FSM states: RX_WAIT, RX_SHIFT, RX_CHECK, TX_GAP, TX_SHIFT.
  - RX_WAIT: a sampled cmd_i=0 moves the FSM to RX_SHIFT, with the bit counter loaded to 1.
  - RX_SHIFT: captures bits 46..0 MSB first into a 48-bit shift register. The CRC7 is computed over bits 47..8. At count 48 the FSM goes to RX_CHECK.
  - RX_CHECK (1 cycle): the token is valid if bit46=1, CRC matches and bit0=1.
    - Invalid token: pulse crc_err_o, set status bit 23 (COM_CRC_ERROR), return to RX_WAIT with no response.
    - Valid token: pulse cmd_valid_o, latch the index and argument, then apply the command table.
- Command table. R1 reports card status = error bits | (state before the command << 9) | bit8 READY_FOR_DATA=1.
  - CMD0: any state → IDLE, RCA reset, no response.
  - CMD1 in IDLE: R3 carrying OCR_VALUE → READY.
  - CMD2 in READY: R2 carrying cid_i → IDENT.
  - CMD3 in IDENT: RCA ← arg[31:16], R1 (0x00000500) → STBY.
  - CMD7 in STBY with arg[31:16]==RCA: R1 (0x00000700) → TRAN.
  - CMD7 in TRAN with a different RCA: → STBY, no response.
  - CMD8 in TRAN: R1 (0x00000900), state unchanged.
  - Any other index/state pair: set status bit 22 (ILLEGAL_COMMAND), no response, state unchanged.
- Error bits 23/22 are cleared in the cycle the R1 carrying them starts shifting.
- Response path:
  - TX_GAP counts NCR cycles with cmd_oe=0, then asserts cmd_oe and enters TX_SHIFT.
  - R1 frame: 48 bits = 0, 0, index, status, CRC7, 1.
  - R3 frame: 48 bits = 0, 0, 6'b111111, OCR, 7'h7F, 1.
  - R2 frame: 136 bits = 0, 0, 6'b111111, cid_i, CRC7 over cid_i, 1.
  - One bit is driven per cycle. cmd_oe drops the cycle after the end bit, and the FSM returns to RX_WAIT.
- cmd_i is ignored from RX_CHECK through TX_SHIFT. A command start during a response is lost and is not an error.
- card_state_o changes in the cycle after RX_CHECK, before the response is sent.
- Reset asserted mid-token or mid-response: immediate return to reset values and cmd_oe=0. No partial frame resumes.

Decomposition:
- Shared package sd_emmc_card_pkg: card state encodings, command index constants (CMD0/1/2/3/7/8), status bit positions (23, 22, 12:9, 8), frame lengths 48/136.
- Sub-module sd_emmc_crc7: serial CRC7 with polynomial x^7+x^3+1 and clear/enable/bit inputs. It is instantiated twice, once for RX and once for TX.

Test Plan:
- CMD0 (token 0x400000000095) then CMD1 with arg 0x00FF8080 → R3 bits 0x3F40FF8080FF; card_state_o=1; cmd_oe rises exactly NCR+1 cycles after the end bit.
- CMD2 in READY with cid_i=120'h15_0100_4D4D43_3332_47 → 136-bit R2 with correct CRC7 → IDENT.
- CMD3 with arg 0x00020000 → R1 status 0x00000500, rca_o=0x0002, state STBY. Then CMD7 with arg 0x00020000 → status 0x00000700, state TRAN.
- CMD8 in TRAN → R1 status 0x00000900. Then CMD2 in TRAN → no response, cmd_oe stays 0. The next CMD8 returns status 0x00400900 and the following one 0x00000900.
- Token with one CRC bit flipped → crc_err_o pulses for 1 cycle, no response. The next R1 has bit 23 set.
- Reset asserted at bit 20 of an R2 → cmd_oe=0 and cmd_o=1 immediately. After release, card_state_o=IDLE and a fresh CMD0/CMD1 sequence works.
